// File: rtl/if_fetch_icache.sv
// Instruction fetch stage backed by a direct-mapped I-cache with one 32-bit word per line.
// Misses are served by the memory controller. A jump takes priority over everything except reset.
module if_fetch_icache #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        jmp_in,
    input  logic [31:0] jmp_target,
    input  logic        stall_in,
    output logic [1:0]  mc_op,
    output logic [1:0]  mc_len,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
);
    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_LSB  = INDEX_BITS + 2;
    localparam int unsigned TAG_BITS = 18 - TAG_LSB;

    // Memory controller encodings
    localparam logic [1:0] MEM_NOP  = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        ign_rdy;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    logic [INDEX_BITS-1:0] idx_c;
    logic [TAG_BITS-1:0]   tag_c;
    logic                  hit_c;
    logic                  fill_c;
    logic                  consume_c;
    logic [31:0]           jmp_pc_c;

    // Lookup is purely combinational on the pc register
    assign idx_c    = pc[TAG_LSB-1:2];
    assign tag_c    = pc[17:TAG_LSB];
    assign hit_c    = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    assign jmp_pc_c = jmp_target & 32'hffff_fffc;

    // Decode took the presented instruction and no replacement is ready
    assign consume_c = id_valid && !stall_in;

    // Line fill: a response in MISS that survives reset, freeze, jump and the post-jump guard
    assign fill_c = !rst_in && rdy_in && !jmp_in && (state == S_MISS)
                    && mc_rdy && !ign_rdy;

    // Valid bits are the only cache state that needs reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (fill_c) begin
            valid_q[idx_c] <= 1'b1;
        end
    end

    // Tag and data arrays, written only on a fill
    always_ff @(posedge clk_in) begin
        if (fill_c) begin
            tag_q[idx_c]  <= tag_c;
            data_q[idx_c] <= mc_data;
        end
    end

    // Fetch FSM: pc, controller request and decode-facing registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= S_RUN;
            pc       <= 32'h0;
            ign_rdy  <= 1'b0;
            id_valid <= 1'b0;
            id_pc    <= 32'h0;
            id_inst  <= 32'h0;
            mc_op    <= MEM_NOP;
            mc_len   <= MEM_WORD;
            mc_addr  <= 32'h0;
        end else if (rdy_in) begin
            ign_rdy <= 1'b0;
            if (jmp_in) begin
                pc       <= jmp_pc_c;
                id_valid <= 1'b0;
                state    <= S_RUN;
                mc_op    <= MEM_NOP;
                ign_rdy  <= 1'b1;
            end else begin
                case (state)
                    S_RUN: begin
                        if (hit_c) begin
                            if (!id_valid || !stall_in) begin
                                id_valid <= 1'b1;
                                id_pc    <= pc;
                                id_inst  <= data_q[idx_c];
                                pc       <= pc + 32'd4;
                            end
                        end else begin
                            if (consume_c) begin
                                id_valid <= 1'b0;
                            end
                            state   <= S_MISS;
                            mc_op   <= MEM_LOAD;
                            mc_addr <= pc;
                        end
                    end
                    S_MISS: begin
                        if (consume_c) begin
                            id_valid <= 1'b0;
                        end
                        if (mc_rdy && !ign_rdy) begin
                            state <= S_RUN;
                            mc_op <= MEM_NOP;
                        end
                    end
                    default: begin
                        state <= S_RUN;
                        mc_op <= MEM_NOP;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_icache.sv
// Directed bench for if_fetch_icache: cold start, warm loop, aliasing, stall, jump during miss, freeze, reset.
module tb_if_fetch_icache;
    localparam logic [1:0] MEM_NOP  = 2'd0;
    localparam logic [1:0] MEM_LOAD = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        jmp_in;
    logic [31:0] jmp_target;
    logic        stall_in;
    logic [1:0]  mc_op;
    logic [1:0]  mc_len;
    logic [31:0] mc_addr;
    logic        mc_rdy;
    logic [31:0] mc_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks = 0;
    int errors = 0;

    logic [31:0] w [4];
    localparam logic [31:0] A1 = 32'h1111_1111;
    localparam logic [31:0] A0 = 32'h2222_2222;
    localparam logic [31:0] W10 = 32'h0100_0213;

    if_fetch_icache #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .jmp_in(jmp_in),
        .jmp_target(jmp_target), .stall_in(stall_in), .mc_op(mc_op), .mc_len(mc_len),
        .mc_addr(mc_addr), .mc_rdy(mc_rdy), .mc_data(mc_data), .id_valid(id_valid),
        .id_pc(id_pc), .id_inst(id_inst)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid got %0b exp 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_id_pc got %h exp 0", id_pc); end
        checks++; if (id_inst !== 32'h0) begin errors++; $display("FAIL reset_id_inst got %h exp 0", id_inst); end
        checks++; if (mc_op !== MEM_NOP) begin errors++; $display("FAIL reset_mc_op got %0d exp %0d", mc_op, MEM_NOP); end
        checks++; if (mc_len !== MEM_WORD) begin errors++; $display("FAIL reset_mc_len got %0d exp %0d", mc_len, MEM_WORD); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL reset_mc_addr got %h exp 0", mc_addr); end
        rst_in = 1'b0;
    endtask

    task automatic test_cold_start();
        tick();
        checks++; if (mc_op !== MEM_LOAD) begin errors++; $display("FAIL cold_req_op got %0d exp %0d", mc_op, MEM_LOAD); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL cold_req_addr got %h exp 0", mc_addr); end
        repeat (7) tick();
        checks++; if (mc_op !== MEM_LOAD) begin errors++; $display("FAIL cold_hold_op got %0d exp %0d", mc_op, MEM_LOAD); end
        checks++; if (mc_addr !== 32'h0) begin errors++; $display("FAIL cold_hold_addr got %h exp 0", mc_addr); end
        mc_rdy = 1'b1; mc_data = w[0];
        tick();
        mc_rdy = 1'b0;
        checks++; if (mc_op !== MEM_NOP) begin errors++; $display("FAIL cold_fill_op got %0d exp %0d", mc_op, MEM_NOP); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL cold_fill_valid got %0b exp 0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL cold_hit_valid got %0b exp 1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL cold_hit_pc got %h exp 0", id_pc); end
        checks++; if (id_inst !== w[0]) begin errors++; $display("FAIL cold_hit_inst got %h exp %h", id_inst, w[0]); end
        tick();
        checks++; if (mc_op !== MEM_LOAD) begin errors++; $display("FAIL cold_next_op got %0d exp %0d", mc_op, MEM_LOAD); end
        checks++; if (mc_addr !== 32'h4) begin errors++; $display("FAIL cold_next_addr got %h exp 4", mc_addr); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL cold_consume got %0b exp 0", id_valid); end
    endtask

    task automatic test_warm_loop();
        for (int i = 1; i < 4; i++) begin
            mc_rdy = 1'b1; mc_data = w[i];
            tick();
            mc_rdy = 1'b0;
            tick();
            checks++; if (id_pc !== 32'(4 * i)) begin errors++; $display("FAIL warm_fill_pc%0d got %h exp %h", i, id_pc, 32'(4 * i)); end
            checks++; if (id_inst !== w[i]) begin errors++; $display("FAIL warm_fill_inst%0d got %h exp %h", i, id_inst, w[i]); end
            if (i < 3) begin
                tick();
                checks++; if (mc_addr !== 32'(4 * (i + 1))) begin errors++; $display("FAIL warm_req_addr%0d got %h exp %h", i, mc_addr, 32'(4 * (i + 1))); end
            end
        end
        jmp_in = 1'b1; jmp_target = 32'h0;
        tick();
        jmp_in = 1'b0;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL warm_jmp_valid got %0b exp 0", id_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL warm_hit_valid%0d got %0b exp 1", i, id_valid); end
            checks++; if (id_pc !== 32'(4 * i)) begin errors++; $display("FAIL warm_hit_pc%0d got %h exp %h", i, id_pc, 32'(4 * i)); end
            checks++; if (id_inst !== w[i]) begin errors++; $display("FAIL warm_hit_inst%0d got %h exp %h", i, id_inst, w[i]); end
            checks++; if (mc_op !== MEM_NOP) begin errors++; $display("FAIL warm_hit_op%0d got %0d exp %0d", i, mc_op, MEM_NOP); end
        end
        tick();
        checks++; if (mc_op !== MEM_LOAD) begin errors++; $display("FAIL warm_exit_op got %0d exp %0d", mc_op, MEM_LOAD); end
        checks++; if (mc_addr !== 32'h10) begin errors++; $display("FAIL warm_exit_addr got %h exp 10", mc_addr); end
    endtask

    task automatic test_alias();
        jmp_in = 1'b1; jmp_target = 32'h100;
        tick();
        jmp_in = 1'b0;
        checks++; if (mc_op !== MEM_NOP) begin errors++; $display("FAIL alias_jmp_op got %0d exp %0d", mc_op, MEM_NOP); end
        tick();
        checks++; if (mc_addr !== 32'h100 || mc_op !== MEM_LOAD) begin errors++; $display("FAIL alias_req100 got %h/%0d exp 100/%0d", mc_addr, mc_op, MEM_LOAD); end
        mc_rdy = 1'b1; mc_data = A1;
        tick();
        mc_rdy = 1'b0;
        tick();
        checks++; if (id_pc !== 32'h100 || id_inst !== A1) begin errors++; $display("FAIL alias_hit100 got %h/%h exp 100/%h", id_pc, id_inst, A1); end
        jmp_in = 1'b1; jmp_target = 32'h0;
        tick();
        jmp_in = 1'b0;
        tick();
        checks++; if (mc_addr !== 32'h0 || mc_op !== MEM_LOAD) begin errors++; $display("FAIL alias_miss0 got %h/%0d exp 0/%0d", mc_addr, mc_op, MEM_LOAD); end
        mc_rdy = 1'b1; mc_data = A0;
        tick();
        mc_rdy = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== A0) begin errors++; $display("FAIL alias_replaced got %0b/%h/%h exp 1/0/%h", id_valid, id_pc, id_inst, A0); end
    endtask

    task automatic test_stall();
        stall_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== A0) begin errors++; $display("FAIL stall_hold%0d got %0b/%h/%h exp 1/0/%h", i, id_valid, id_pc, id_inst, A0); end
            checks++; if (mc_op !== MEM_NOP) begin errors++; $display("FAIL stall_op%0d got %0d exp %0d", i, mc_op, MEM_NOP); end
        end
        stall_in = 1'b0;
        tick();
        checks++; if (id_pc !== 32'h4 || id_inst !== w[1]) begin errors++; $display("FAIL stall_release got %h/%h exp 4/%h", id_pc, id_inst, w[1]); end
        tick();
        tick();
        checks++; if (id_pc !== 32'hc || id_inst !== w[3]) begin errors++; $display("FAIL stall_run got %h/%h exp c/%h", id_pc, id_inst, w[3]); end
        tick();
        checks++; if (mc_addr !== 32'h10 || mc_op !== MEM_LOAD || id_valid !== 1'b0) begin errors++; $display("FAIL stall_miss got %h/%0d/%0b exp 10/%0d/0", mc_addr, mc_op, id_valid, MEM_LOAD); end
    endtask

    task automatic test_jump_miss();
        jmp_in = 1'b1; jmp_target = 32'h203; mc_rdy = 1'b1; mc_data = 32'hdead_beef;
        tick();
        jmp_in = 1'b0;
        checks++; if (id_valid !== 1'b0 || mc_op !== MEM_NOP) begin errors++; $display("FAIL jmiss_jump got %0b/%0d exp 0/%0d", id_valid, mc_op, MEM_NOP); end
        tick();
        mc_rdy = 1'b0;
        checks++; if (mc_addr !== 32'h200 || mc_op !== MEM_LOAD) begin errors++; $display("FAIL jmiss_req got %h/%0d exp 200/%0d", mc_addr, mc_op, MEM_LOAD); end
        jmp_in = 1'b1; jmp_target = 32'h0;
        tick();
        jmp_in = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== A0 || mc_op !== MEM_NOP) begin errors++; $display("FAIL jmiss_cache0 got %0b/%h/%h/%0d exp 1/0/%h/0", id_valid, id_pc, id_inst, mc_op, A0); end
        jmp_in = 1'b1; jmp_target = 32'h10;
        tick();
        jmp_in = 1'b0;
        tick();
        checks++; if (mc_addr !== 32'h10 || mc_op !== MEM_LOAD) begin errors++; $display("FAIL jmiss_nowrite got %h/%0d exp 10/%0d", mc_addr, mc_op, MEM_LOAD); end
    endtask

    task automatic test_freeze();
        rdy_in = 1'b0; mc_rdy = 1'b1; mc_data = W10;
        for (int i = 0; i < 3; i++) begin
            jmp_in = (i == 1); jmp_target = 32'h300;
            tick();
            checks++; if (mc_op !== MEM_LOAD || mc_addr !== 32'h10 || id_valid !== 1'b0) begin errors++; $display("FAIL freeze_hold%0d got %0d/%h/%0b exp %0d/10/0", i, mc_op, mc_addr, id_valid, MEM_LOAD); end
        end
        jmp_in = 1'b0;
        rdy_in = 1'b1;
        tick();
        mc_rdy = 1'b0;
        checks++; if (mc_op !== MEM_NOP) begin errors++; $display("FAIL freeze_fill_op got %0d exp %0d", mc_op, MEM_NOP); end
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_inst !== W10) begin errors++; $display("FAIL freeze_hit got %0b/%h/%h exp 1/10/%h", id_valid, id_pc, id_inst, W10); end
    endtask

    task automatic test_reset_miss();
        tick();
        checks++; if (mc_addr !== 32'h14 || mc_op !== MEM_LOAD) begin errors++; $display("FAIL rmiss_req got %h/%0d exp 14/%0d", mc_addr, mc_op, MEM_LOAD); end
        rst_in = 1'b1; jmp_in = 1'b1; jmp_target = 32'h400; mc_rdy = 1'b1; mc_data = 32'hbad0_bad0;
        tick();
        rst_in = 1'b0; jmp_in = 1'b0; mc_rdy = 1'b0;
        checks++; if (mc_op !== MEM_NOP || mc_addr !== 32'h0 || id_valid !== 1'b0 || mc_len !== MEM_WORD) begin errors++; $display("FAIL rmiss_reset got %0d/%h/%0b/%0d exp 0/0/0/%0d", mc_op, mc_addr, id_valid, mc_len, MEM_WORD); end
        tick();
        checks++; if (mc_addr !== 32'h0 || mc_op !== MEM_LOAD) begin errors++; $display("FAIL rmiss_cold got %h/%0d exp 0/%0d", mc_addr, mc_op, MEM_LOAD); end
    endtask

    initial begin
        w[0] = 32'h0000_0013;
        w[1] = 32'h0040_0093;
        w[2] = 32'h0080_0113;
        w[3] = 32'h00c0_0193;
        rst_in = 1'b1; rdy_in = 1'b1; jmp_in = 1'b0; jmp_target = 32'h0;
        stall_in = 1'b0; mc_rdy = 1'b0; mc_data = 32'h0;
        test_reset();
        test_cold_start();
        test_warm_loop();
        test_alias();
        test_stall();
        test_jump_miss();
        test_freeze();
        test_reset_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_icache.md
IF_FETCH_ICACHE -- requirements
Module: if_fetch_icache

Interface
- REQ-001: The block SHALL have parameter INDEX_BITS, default 6, giving the log2 of the number of direct-mapped I-cache lines (64 lines, one 32-bit word each).
- REQ-002: The block SHALL have port clk_in, input, 1 bit: system clock; all state updates on posedge.
- REQ-003: The block SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
- REQ-004: The block SHALL have port rdy_in, input, 1 bit: when low, all registers hold.
- REQ-005: The block SHALL have port jmp_in, input, 1 bit: redirect request; the same signal drives the memory controller's take_jmp.
- REQ-006: The block SHALL have port jmp_target, input, 32 bits: redirect PC; bits [1:0] are ignored (treated as 0).
- REQ-007: The block SHALL have port stall_in, input, 1 bit: decode cannot accept a new instruction.
- REQ-008: The block SHALL have port mc_op, output, 2 bits: request op to the memory controller, `MEM_LOAD or `MEM_NOP.
- REQ-009: The block SHALL have port mc_len, output, 2 bits: request length to the memory controller, always `MEM_WORD.
- REQ-010: The block SHALL have port mc_addr, output, 32 bits: word address of the fetch request.
- REQ-011: The block SHALL have port mc_rdy, input, 1 bit: controller completion; it may stay high for more than one cycle.
- REQ-012: The block SHALL have port mc_data, input, 32 bits: fetched little-endian word, valid while mc_rdy is high.
- REQ-013: The block SHALL have port id_valid, output, 1 bit: id_pc and id_inst hold a valid instruction.
- REQ-014: The block SHALL have port id_pc, output, 32 bits: PC of the instruction presented to decode.
- REQ-015: The block SHALL have port id_inst, output, 32 bits: instruction presented to decode.

Function
- REQ-016: Address split SHALL be: index = pc[INDEX_BITS+1:2]; tag = pc[17:INDEX_BITS+2]. Only address bits 17:0 are significant.
- REQ-017: Storage SHALL be one valid bit, one tag and one 32-bit data word per line.
- REQ-018: Lookup SHALL be combinational on the pc register. A hit requires the line's valid bit set and its tag equal to the pc tag.
- REQ-019: The FSM SHALL have exactly two states, RUN and MISS.
- REQ-020: RUN with a hit, when id_valid is 0 or stall_in is 0: next cycle id_valid=1, id_pc=pc, id_inst=the line's data word, pc=pc+4 (32-bit wrap).
- REQ-021: RUN with a hit, when id_valid is 1 and stall_in is 1: pc and all id_* registers SHALL hold.
- REQ-022: Decode consume rule: when id_valid is 1, stall_in is 0 and there is no hit, id_valid SHALL go to 0 next cycle.
- REQ-023: RUN with a miss: next cycle state=MISS, mc_op=`MEM_LOAD, mc_addr=pc. mc_op and mc_addr SHALL stay stable throughout MISS.
- REQ-024: MISS, when mc_rdy is 1 and ign_rdy is 0: write valid=1, tag and mc_data into the indexed line; next cycle mc_op=`MEM_NOP, state=RUN. The following cycle SHALL be a hit.
- REQ-025: MISS SHALL continue to apply the consume rule of REQ-022. stall_in SHALL NOT delay the line fill.
- REQ-026: Hit latency SHALL be 1 cycle from the pc update to id_valid.
- REQ-027: Miss latency SHALL be the controller latency plus 2 cycles (one fill cycle, one hit cycle).
- REQ-028: mc_rdy received in RUN SHALL be ignored; no cache write occurs.
- REQ-029: jmp_in=1 SHALL take priority over all other events, including stall_in and mc_rdy in the same cycle. Next cycle: pc={jmp_target[31:2],2'b00}, id_valid=0, state=RUN, mc_op=`MEM_NOP, ign_rdy=1.
- REQ-030: ign_rdy SHALL be 1 in the cycle after a jump and 0 otherwise. While ign_rdy is 1, a stale mc_rdy is discarded and the cache is not written.
- REQ-031: rdy_in=0 SHALL freeze pc, state, cache arrays and every output register. jmp_in is also ignored while rdy_in is 0.
- REQ-032: The block SHALL never issue `MEM_SAVE.
- REQ-033: mc_len SHALL be constant `MEM_WORD.

Reset
- REQ-034: rst_in=1 at posedge SHALL set: pc=0, state=RUN, all valid bits=0, id_valid=0, id_pc=0, id_inst=0, mc_op=`MEM_NOP, mc_len=`MEM_WORD, mc_addr=0, ign_rdy=0.
- REQ-035: rst_in SHALL take priority over rdy_in and jmp_in.
- REQ-036: A reset during MISS SHALL abandon the miss; no cache line is written.
- REQ-037: Tag and data arrays need no reset, because the valid bits gate every hit.

Verification
- REQ-038: Cold start. After reset, respond to mc_addr=0 with mc_data=32'h00000013 after 8 cycles. Expect id_valid=1, id_pc=0, id_inst=32'h00000013 two cycles after mc_rdy, and mc_addr=4 issued next.
- REQ-039: Warm loop. Fetch 0x0–0xC, then jump to 0x0. Expect 4 consecutive hit cycles with no mc_op=`MEM_LOAD.
- REQ-040: Alias. Fill index of 0x100 (INDEX_BITS=6), then fetch 0x000 with the same index and a different tag. Expect a miss, and the line replaced with the new word.
- REQ-041: Jump during miss. Issue jmp_in=1 with jmp_target=0x203 while in MISS, and drive mc_rdy=1 in that cycle and the next. Expect pc=0x200, id_valid=0, the cache unchanged, then a new request with mc_addr=0x200.
- REQ-042: Stall. With id_valid=1, hold stall_in=1 for 5 cycles. Expect id_pc, id_inst and pc unchanged; on release, the next instruction appears in 1 cycle.
- REQ-043: Freeze. Drop rdy_in for 3 cycles in the cycle mc_rdy=1. Expect no state change; the fill completes when rdy_in returns, provided mc_rdy is still high.
